// File: rtl/data_sram_resp.sv
// Data-SRAM responder: word-organised RAM plus an MMIO page (TIMER, LED, NUM).
// Every request is answered with a registered read response after exactly one cycle.
module data_sram_resp #(
  parameter int          ADDR_W  = 14,
  parameter logic [15:0] MMIO_HI = 16'hbfaf
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        data_sram_rvalid,
  output logic [15:0] led,
  output logic [31:0] num
);

  localparam logic [15:0] OFF_TIMER = 16'he000;
  localparam logic [15:0] OFF_LED   = 16'hf020;
  localparam logic [15:0] OFF_NUM   = 16'hf050;

  // Handshake: a request is accepted whenever data_sram_en is high outside reset;
  // there is no ready. The response (rdata, rvalid) appears after the next edge.

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] ram_idx;
  logic [15:0]       offset;
  logic              is_mmio;
  logic              req;
  logic              wr;
  logic              sel_timer;
  logic              sel_led;
  logic              sel_num;
  logic [31:0]       timer;
  logic [31:0]       mmio_rd;
  logic [31:0]       ram_q;
  logic [31:0]       mmio_q;
  logic              src_ram_q;
  logic              rvalid_q;
  logic              unused_addr;

  // Low address bits and bits above the RAM index only matter through decode.
  assign unused_addr = ^data_sram_addr;

  assign ram_idx   = data_sram_addr[ADDR_W+1:2];
  assign offset    = data_sram_addr[15:0];
  assign is_mmio   = (data_sram_addr[31:16] == MMIO_HI);
  assign req       = data_sram_en & ~reset;
  assign wr        = req & (|data_sram_we);
  assign sel_timer = is_mmio & (offset == OFF_TIMER);
  assign sel_led   = is_mmio & (offset == OFF_LED);
  assign sel_num   = is_mmio & (offset == OFF_NUM);

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] new_val,
                                        input logic [3:0]  lanes);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  always_comb begin
    mmio_rd = 32'h0;
    if (sel_timer)    mmio_rd = timer;
    else if (sel_led) mmio_rd = {16'h0, led};
    else if (sel_num) mmio_rd = num;
  end

  // RAM is never reset; the old word is captured before the write lands (read-first).
  always_ff @(posedge clk) begin
    if (req && !is_mmio) begin
      ram_q <= mem[ram_idx];
      for (int i = 0; i < 4; i++) begin
        if (data_sram_we[i]) mem[ram_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mmio_q    <= 32'h0;
      src_ram_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      rvalid_q <= data_sram_en & ~(|data_sram_we);
      if (data_sram_en) begin
        mmio_q    <= mmio_rd;
        src_ram_q <= ~is_mmio;
      end
    end
  end

  // A TIMER write replaces the increment for that cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer <= 32'h0;
    end else if (wr && sel_timer) begin
      timer <= merge(timer, data_sram_wdata, data_sram_we);
    end else begin
      timer <= timer + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led <= 16'h0;
      num <= 32'h0;
    end else begin
      if (wr && sel_led) led <= merge({16'h0, led}, data_sram_wdata, {2'b00, data_sram_we[1:0]}) >> 0;
      if (wr && sel_num) num <= merge(num, data_sram_wdata, data_sram_we);
    end
  end

  assign data_sram_rdata  = src_ram_q ? ram_q : mmio_q;
  assign data_sram_rvalid = rvalid_q;

endmodule

// File: tb/tb_data_sram_resp.sv
// Directed bench for data_sram_resp: reset, RAM lanes, read-first, MMIO, TIMER, reset squash.
module tb_data_sram_resp;

  logic        clk = 1'b0;
  logic        reset;
  logic        data_sram_en;
  logic [3:0]  data_sram_we;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic [31:0] data_sram_rdata;
  logic        data_sram_rvalid;
  logic [15:0] led;
  logic [31:0] num;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  localparam logic [31:0] A_TIMER = 32'hbfafe000;
  localparam logic [31:0] A_LED   = 32'hbfaff020;
  localparam logic [31:0] A_NUM   = 32'hbfaff050;
  localparam logic [31:0] A_OTHER = 32'hbfaff100;
  localparam logic [31:0] A_RAM   = 32'h1c000100;
  localparam logic [31:0] A_RAM2  = 32'h1c000200;

  data_sram_resp dut (
    .clk              (clk),
    .reset            (reset),
    .data_sram_en     (data_sram_en),
    .data_sram_we     (data_sram_we),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wdata  (data_sram_wdata),
    .data_sram_rdata  (data_sram_rdata),
    .data_sram_rvalid (data_sram_rvalid),
    .led              (led),
    .num              (num)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks: present one request for one edge, then go idle.
  task automatic cycle(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata);
    data_sram_en    = 1'b1;
    data_sram_we    = we;
    data_sram_addr  = addr;
    data_sram_wdata = wdata;
    tick();
    data_sram_en = 1'b0;
    data_sram_we = 4'h0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] we);
    cycle(we, addr, wdata);
  endtask

  task automatic rd(input logic [31:0] addr);
    cycle(4'h0, addr, 32'h0);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_empty_q"}, 32'h1, 32'h0);
    end else begin
      e = exp_q.pop_front();
      check(tag, data_sram_rdata, e);
    end
  endtask

  initial begin
    reset           = 1'b1;
    data_sram_en    = 1'b0;
    data_sram_we    = 4'h0;
    data_sram_addr  = 32'h0;
    data_sram_wdata = 32'h0;

    // Reset then idle
    tick();
    tick();
    check("rst_rdata",  data_sram_rdata, 32'h0);
    check("rst_rvalid", {31'h0, data_sram_rvalid}, 32'h1 & 32'h0);
    check("rst_led",    {16'h0, led}, 32'h0);
    check("rst_num",    num, 32'h0);
    reset = 1'b0;
    rd(A_TIMER);
    check("timer0_rvalid", {31'h0, data_sram_rvalid}, 32'h1);
    check("timer0_rdata",  data_sram_rdata, 32'h0);
    for (int i = 0; i < 9; i++) tick();
    rd(A_TIMER);
    check("timer10_rdata", data_sram_rdata, 32'd10);

    // RAM byte lanes
    wr(A_RAM, 32'h11223344, 4'hf);
    check("wr_rvalid", {31'h0, data_sram_rvalid}, 32'h0);
    rd(A_RAM);
    exp_q.push_back(32'h11223344);
    check_pop("lane_full");
    wr(A_RAM, 32'hAAAAAAAA, 4'b0100);
    rd(A_RAM);
    exp_q.push_back(32'h11AA3344);
    check_pop("lane_2");
    wr(A_RAM, 32'hBEEFBEEF, 4'b0011);
    rd(A_RAM);
    exp_q.push_back(32'h11AABEEF);
    check_pop("lane_01");
    rd(A_RAM + 32'h0001_0000);
    exp_q.push_back(32'h11AABEEF);
    check_pop("ram_alias");

    // Read-first and back-to-back
    wr(A_RAM2, 32'h0, 4'hf);
    wr(A_RAM2 + 32'd4, 32'h5a5a1234, 4'hf);
    wr(A_RAM2, 32'hdeadbeef, 4'hf);
    check("rf_old_rdata", data_sram_rdata, 32'h0);
    check("rf_wr_rvalid", {31'h0, data_sram_rvalid}, 32'h0);
    rd(A_RAM2);
    check("b2b_new_rdata",  data_sram_rdata, 32'hdeadbeef);
    check("b2b_new_rvalid", {31'h0, data_sram_rvalid}, 32'h1);
    rd(A_RAM2 + 32'd4);
    check("b2b_next_rdata",  data_sram_rdata, 32'h5a5a1234);
    check("b2b_next_rvalid", {31'h0, data_sram_rvalid}, 32'h1);
    tick();
    check("idle_rvalid", {31'h0, data_sram_rvalid}, 32'h0);
    check("idle_hold",   data_sram_rdata, 32'h5a5a1234);

    // MMIO
    wr(A_LED, 32'h1234ffff, 4'hf);
    check("led_write", {16'h0, led}, 32'h0000ffff);
    rd(A_LED);
    check("led_read", data_sram_rdata, 32'h0000ffff);
    wr(A_NUM, 32'hcafef00d, 4'hf);
    check("num_write", num, 32'hcafef00d);
    rd(A_NUM);
    check("num_read", data_sram_rdata, 32'hcafef00d);
    rd(A_OTHER);
    check("other_read",   data_sram_rdata, 32'h0);
    check("other_rvalid", {31'h0, data_sram_rvalid}, 32'h1);
    wr(A_OTHER, 32'h55555555, 4'hf);
    check("other_wr_led", {16'h0, led}, 32'h0000ffff);
    check("other_wr_num", num, 32'hcafef00d);

    // TIMER edge cases
    wr(A_TIMER, 32'hfffffffe, 4'hf);
    rd(A_TIMER);
    check("timer_fe", data_sram_rdata, 32'hfffffffe);
    rd(A_TIMER);
    check("timer_ff", data_sram_rdata, 32'hffffffff);
    rd(A_TIMER);
    check("timer_wrap", data_sram_rdata, 32'h0);
    wr(A_TIMER, 32'h12345678, 4'hf);
    wr(A_TIMER, 32'h000000aa, 4'b0001);
    check("timer_wr_rd_old", data_sram_rdata, 32'h12345678);
    rd(A_TIMER);
    check("timer_lane0", data_sram_rdata, 32'h123456aa);

    // Reset mid-traffic
    rd(A_RAM);
    check("pre_rst_rvalid", {31'h0, data_sram_rvalid}, 32'h1);
    check("pre_rst_rdata",  data_sram_rdata, 32'h11AABEEF);
    reset = 1'b1;
    data_sram_en    = 1'b1;
    data_sram_we    = 4'hf;
    data_sram_addr  = A_RAM;
    data_sram_wdata = 32'h0badf00d;
    tick();
    data_sram_en = 1'b0;
    data_sram_we = 4'h0;
    reset = 1'b0;
    check("squash_rvalid", {31'h0, data_sram_rvalid}, 32'h0);
    check("squash_rdata",  data_sram_rdata, 32'h0);
    check("squash_led",    {16'h0, led}, 32'h0);
    check("squash_num",    num, 32'h0);
    rd(A_RAM);
    check("ram_kept", data_sram_rdata, 32'h11AABEEF);
    rd(A_TIMER);
    check("timer_after_rst", data_sram_rdata, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Responder end of the CPU data-SRAM interface. It answers the requests that the execute stage drives (`data_sram_en`, `data_sram_we`, `data_sram_addr`, `data_sram_wdata`) with a fixed 1-cycle read latency. The responder holds a word-organised on-chip data RAM and a small memory-mapped register page: LED, NUM and a free-running TIMER. It sits at SoC level between the CPU core and the board outputs, and also serves as the data-memory model for CPU simulation.

## Interface
Parameters:
- `ADDR_W`, default 14: RAM depth is 2^ADDR_W 32-bit words.
- `MMIO_HI`, default 16'hbfaf: value of `addr[31:16]` that selects the MMIO page.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `data_sram_en`  input  1  request valid this cycle.
- `data_sram_we`  input  4  byte-lane write enables; bit i enables `wdata[8i+7:8i]`. 0 means read.
- `data_sram_addr`  input  32  byte address; bits [1:0] are ignored (the initiator sends word-aligned addresses).
- `data_sram_wdata`  input  32  write data, already lane-replicated by the initiator.
- `data_sram_rdata`  output  32  read data, registered.
- `data_sram_rvalid`  output  1  pulses high on the cycle `rdata` carries a read response.
- `led`  output  16  LED register contents.
- `num`  output  32  NUM register contents.

## Operation
Address decode, per request:
- MMIO when `addr[31:16] == MMIO_HI`; otherwise RAM.
- RAM index is `addr[ADDR_W+1:2]`; higher address bits are ignored, so the RAM aliases.

MMIO offsets, using `addr[15:0]`:
- 16'he000: TIMER (32-bit, read/write).
- 16'hf020: LED (low 16 bits; read returns {16'h0, led}; write lanes 2 and 3 are ignored).
- 16'hf050: NUM (32-bit, read/write).
- Any other offset: reads return 0, writes have no effect.

Writes (`en & |we`):
- Only the enabled byte lanes of the target word or register are updated.
- Lanes with `we` = 0 keep their old bytes.

Reads:
- Every cycle with `en` = 1 (read or write) captures the addressed location into `rdata` at the next edge.
- Read-first: the captured value is the content before any write in the same cycle.
- `rvalid` is `en & ~|we`, registered.
- When `en` = 0, `rdata` holds its previous value and `rvalid` is 0 next cycle.

TIMER:
- Every cycle not writing TIMER: `timer <= timer + 1`, wrapping 32'hffffffff to 0.
- On a TIMER write cycle: `timer <=` byte-merged write value, with no increment that cycle.
- A TIMER read returns the value in the request cycle, before the increment.

No back-pressure exists: every request is accepted in its cycle and the initiator never waits.

## Timing
- Read latency is exactly 1 cycle: request at edge N, so `rdata`/`rvalid` are valid after edge N+1 and stay stable until the next `en` cycle.
- Back-to-back requests are supported every cycle, for both reads and writes to any mix of RAM and MMIO.
- A write at cycle N followed by a read of the same address at N+1 returns the new data.
- Reset, when `reset` = 1 at an edge:
  - Outputs `rdata` = 0, `rvalid` = 0, `led` = 0, `num` = 0.
  - TIMER = 0.
  - RAM contents are not reset and are preserved across reset.
  - Requests presented during a reset cycle are dropped: no write occurs and no response is produced.
- Reset asserted in the cycle after a read request: the response is squashed (`rvalid` = 0, `rdata` = 0).
- Simultaneous TIMER write and increment: the write wins.

## Test plan
- Reset then idle: hold `reset` 2 cycles -> `rdata` = 0, `rvalid` = 0, `led` = 0, `num` = 0. Release and read TIMER immediately -> `rvalid` = 1 one cycle later, `rdata` = 0. Read again 10 cycles later -> `rdata` = 10.
- RAM byte lanes:
  - Write 32'h11223344, `we` 4'hf, address 0x1c000100; read it back -> 32'h11223344.
  - Write `wdata` 32'hAAAAAAAA with `we` 4'b0100 -> readback 32'h11AA3344.
  - Write `wdata` 32'hBEEFBEEF with `we` 4'b0011 -> readback 32'h11AABEEF.
- Read-first and back-to-back: cycle N writes 32'hdeadbeef to address A, which held 32'h0. Cycle N+1 reads A, cycle N+2 reads A+4.
  - At N+1: `rdata` = 0, `rvalid` = 0.
  - At N+2: `rdata` = 32'hdeadbeef, `rvalid` = 1.
  - At N+3: `rdata` = contents of A+4, `rvalid` = 1.
- MMIO:
  - Write LED with 32'h1234ffff, `we` 4'hf -> `led` = 16'hffff; a read returns 32'h0000ffff.
  - Write NUM with 32'hcafef00d -> `num` = 32'hcafef00d.
  - Read offset 16'hf100 -> 0.
  - Write 16'hf100 -> no output changes.
- TIMER edge cases:
  - Write 32'hfffffffe; reads on the next two cycles -> 32'hfffffffe, then 32'hffffffff. A read one cycle later -> 32'h0.
  - Write with `we` 4'b0001, `wdata` 32'h000000aa, while timer = 32'h12345678 -> timer = 32'h123456aa.
- Reset mid-traffic: issue a read, assert `reset` the next cycle -> `rvalid` = 0, `rdata` = 0. A RAM word written before the reset reads back unchanged after it.
